// File: rtl/au_pkg.sv
// rtl/au_pkg.sv - shared opcode encoding and widths for the arith_unit lane
package au_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASS2  = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_EQ     = 5'd15,
    OP_NE     = 5'd16,
    OP_LT     = 5'd17,
    OP_GE     = 5'd18,
    OP_LTU    = 5'd19,
    OP_GEU    = 5'd20
  } au_op_e;

endpackage

// File: rtl/au_mul.sv
// rtl/au_mul.sv - combinational 33x33 signed multiplier returning the 64-bit product
module au_mul
  import au_pkg::*;
(
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              a_signed_i,
  input  logic              b_signed_i,
  output logic [2*XLEN-1:0] prod_o
);

  logic signed [XLEN:0]     a_ext;
  logic signed [XLEN:0]     b_ext;
  logic signed [2*XLEN+1:0] prod_full;
  logic                     prod_unused;

  // One extra bit lets every signed/unsigned mix share a single signed multiplier.
  assign a_ext = {a_signed_i & a_i[XLEN-1], a_i};
  assign b_ext = {b_signed_i & b_i[XLEN-1], b_i};

  assign prod_full   = a_ext * b_ext;
  assign prod_o      = prod_full[2*XLEN-1:0];
  assign prod_unused = ^prod_full[2*XLEN+1:2*XLEN];

endmodule

// File: rtl/arith_unit.sv
// rtl/arith_unit.sv - RV32IM integer ALU/compare/multiply lane with one-cycle registered result
module arith_unit
  import au_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [4:0]      execute_type,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0]    result_d;
  logic [XLEN-1:0]    result_q;
  logic [SHAMT_W-1:0] shamt;
  logic               eq;
  logic               lt_s;
  logic               lt_u;
  logic               mul_a_signed;
  logic               mul_b_signed;
  logic [2*XLEN-1:0]  product;

  assign shamt = operand2[SHAMT_W-1:0];
  assign eq    = (operand1 == operand2);
  assign lt_s  = ($signed(operand1) < $signed(operand2));
  assign lt_u  = (operand1 < operand2);

  // MUL takes the low half, which is the same for any signedness.
  assign mul_a_signed = (execute_type == OP_MULH) || (execute_type == OP_MULHSU);
  assign mul_b_signed = (execute_type == OP_MULH);

  au_mul u_mul (
    .a_i        (operand1),
    .b_i        (operand2),
    .a_signed_i (mul_a_signed),
    .b_signed_i (mul_b_signed),
    .prod_o     (product)
  );

  always_comb begin
    result_d = '0;
    case (execute_type)
      OP_ADD:    result_d = operand1 + operand2;
      OP_SUB:    result_d = operand1 - operand2;
      OP_SLL:    result_d = operand1 << shamt;
      OP_SLT:    result_d = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:   result_d = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:    result_d = operand1 ^ operand2;
      OP_SRL:    result_d = operand1 >> shamt;
      OP_SRA:    result_d = $signed(operand1) >>> shamt;
      OP_OR:     result_d = operand1 | operand2;
      OP_AND:    result_d = operand1 & operand2;
      OP_PASS2:  result_d = operand2;
      OP_MUL:    result_d = product[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result_d = product[2*XLEN-1:XLEN];
      OP_EQ:     result_d = {{(XLEN-1){1'b0}}, eq};
      OP_NE:     result_d = {{(XLEN-1){1'b0}}, ~eq};
      OP_LT:     result_d = {{(XLEN-1){1'b0}}, lt_s};
      OP_GE:     result_d = {{(XLEN-1){1'b0}}, ~lt_s};
      OP_LTU:    result_d = {{(XLEN-1){1'b0}}, lt_u};
      OP_GEU:    result_d = {{(XLEN-1){1'b0}}, ~lt_u};
      default:   result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_arith_unit.sv
// tb/tb_arith_unit.sv - self-checking bench for arith_unit against a behavioural model
module tb_arith_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  et;
  logic [31:0] result;
  logic [31:0] exp_q;
  logic        cmp_en;
  int          checks;
  int          errors;

  arith_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .operand1     (op1),
    .operand2     (op2),
    .execute_type (et),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned sh;
    logic [63:0] pu;
    longint      pss;
    longint      psu;
    sa  = int'(a);
    sb  = int'(b);
    sh  = int'(b[4:0]);
    pu  = {32'b0, a} * {32'b0, b};
    pss = longint'(sa) * longint'(sb);
    psu = longint'(sa) * longint'({32'b0, b});
    case (int'(t))
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return 32'(sa >>> sh);
      8:  return a | b;
      9:  return a & b;
      10: return b;
      11: return pu[31:0];
      12: return 32'(pss >>> 32);
      13: return 32'(psu >>> 32);
      14: return pu[63:32];
      15: return (a == b) ? 32'd1 : 32'd0;
      16: return (a != b) ? 32'd1 : 32'd0;
      17: return (sa < sb) ? 32'd1 : 32'd0;
      18: return (sa >= sb) ? 32'd1 : 32'd0;
      19: return (a < b) ? 32'd1 : 32'd0;
      20: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Expected output register: cleared by reset, otherwise last sampled op.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q = 32'd0;
    else        exp_q = model(et, op1, op2);
  end

  always @(negedge clk) begin
    if (cmp_en) check("stream", result, exp_q);
  end

  task automatic vec(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expv, input string nm);
    @(negedge clk);
    op1 = a;
    op2 = b;
    et  = t;
    @(posedge clk);
    #1;
    check(nm, result, expv);
    check({nm, "_model"}, model(t, a, b), expv);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    op1    = 32'd0;
    op2    = 32'd0;
    et     = 5'd0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op1 = $urandom;
      op2 = $urandom;
      et  = 5'($urandom_range(0, 20));
      @(posedge clk);
      #1;
      check("reset_hold", result, 32'd0);
    end

    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    vec(5'd0,  32'd5,        32'd7,        32'd12,       "add_after_reset");
    vec(5'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        "add_wrap");
    vec(5'd1,  32'd0,        32'd1,        32'hFFFFFFFF, "sub_wrap");
    vec(5'd2,  32'd1,        32'h23,       32'd8,        "sll_shamt3");
    vec(5'd2,  32'hDEADBEEF, 32'h20,       32'hDEADBEEF, "sll_by0");
    vec(5'd6,  32'h80000000, 32'd31,       32'd1,        "srl_31");
    vec(5'd7,  32'h80000000, 32'd31,       32'hFFFFFFFF, "sra_31");
    vec(5'd3,  32'hFFFFFFFF, 32'd1,        32'd1,        "slt");
    vec(5'd4,  32'hFFFFFFFF, 32'd1,        32'd0,        "sltu");
    vec(5'd15, 32'd5,        32'd5,        32'd1,        "eq");
    vec(5'd20, 32'd0,        32'hFFFFFFFF, 32'd0,        "geu");
    vec(5'd18, 32'h80000000, 32'h80000000, 32'd1,        "ge_equal");
    vec(5'd11, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, "mul");
    vec(5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    vec(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "mulh_neg1");
    vec(5'd12, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    vec(5'd13, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu");
    vec(5'd10, 32'hAAAAAAAA, 32'h12345000, 32'h12345000, "pass2");
    vec(5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
    vec(5'd8,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, "or");
    vec(5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
    vec(5'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        "reserved25");
    vec(5'd16, 32'd3,        32'd4,        32'd1,        "ne");
    vec(5'd17, 32'hFFFFFFFE, 32'd0,        32'd1,        "lt");
    vec(5'd19, 32'd7,        32'd7,        32'd0,        "ltu_equal");

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      op1 = $urandom;
      op2 = (i % 4 == 0) ? op1 : $urandom;
      et  = 5'($urandom_range(0, 31));
    end

    vec(5'd0, 32'd5, 32'd7, 32'd12, "add_before_midreset");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec(5'd0, 32'd5, 32'd7, 32'd12, "add_after_midreset");

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
